// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO special registers.
// The unit runs a WIDTH-step shift-add multiply or restoring divide on operand
// magnitudes, applies the sign correction in ADJUST, and then commits the
// result to hi/lo on the following edge together with a one-cycle done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ADJUST = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CW-1:0]    counter;
  logic [1:0]       opReg;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] origA;
  logic [WIDTH-1:0] addend;   // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] accHi;    // product upper half / partial remainder
  logic [WIDTH-1:0] accLo;    // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;
  logic             wbPending;

  // Control decode
  logic loadOps;
  logic doIter;
  logic doAdjust;
  logic hostWrHi;
  logic hostWrLo;

  // Operand preparation at start
  logic             inSigned;
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  // Iteration and adjust datapath
  logic             isDiv;
  logic             isSigned;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divDiff;
  logic [WIDTH-1:0] iterHi;
  logic [WIDTH-1:0] iterLo;
  logic [2*WIDTH-1:0] negProduct;
  logic [WIDTH-1:0] adjHi;
  logic [WIDTH-1:0] adjLo;

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic: CALC runs until the counter steps from 1 to 0
  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an uncovered path would infer a latch.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (counter == CW'(1)) stateNext = ADJUST;
      ADJUST:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output/control decode: start has priority over mthi/mtlo in IDLE
  always_comb begin
    loadOps  = (state == IDLE) && start;
    hostWrHi = (state == IDLE) && !start && mthi;
    hostWrLo = (state == IDLE) && !start && mtlo;
    doIter   = (state == CALC);
    doAdjust = (state == ADJUST);
  end

  // Operand magnitudes and recorded signs for the op being started
  always_comb begin
    inSigned = ~op[0];
    negA     = inSigned & rs_data[WIDTH-1];
    negB     = inSigned & rt_data[WIDTH-1];
    magA     = negA ? -rs_data : rs_data;
    magB     = negB ? -rt_data : rt_data;
  end

  // One multiply or restoring-divide step on the shared accumulator
  always_comb begin
    isDiv    = opReg[1];
    isSigned = ~opReg[0];
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, addend} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {2'b00, addend};
    if (isDiv) begin
      if (!divDiff[WIDTH+1]) begin
        iterHi = divDiff[WIDTH-1:0];
        iterLo = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        iterHi = divShift[WIDTH-1:0];
        iterLo = {accLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      iterHi = mulSum[WIDTH:1];
      iterLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  // Sign correction; divide by zero bypasses it and returns the raw dividend
  always_comb begin
    negProduct = -{accHi, accLo};
    adjHi      = accHi;
    adjLo      = accLo;
    if (isDiv) begin
      if (addend == '0) begin
        adjHi = origA;
        adjLo = '1;
      end else begin
        if (isSigned && (signA ^ signB)) adjLo = -accLo;
        if (isSigned && signA)           adjHi = -accHi;
      end
    end else if (isSigned && (signA ^ signB)) begin
      {adjHi, adjLo} = negProduct;
    end
  end

  // Datapath, result commit and HI/LO host writes
  always_ff @(posedge clk) begin
    if (reset) begin
      counter   <= '0;
      opReg     <= '0;
      signA     <= 1'b0;
      signB     <= 1'b0;
      origA     <= '0;
      addend    <= '0;
      accHi     <= '0;
      accLo     <= '0;
      resHi     <= '0;
      resLo     <= '0;
      wbPending <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy      <= (stateNext != IDLE);
      wbPending <= doAdjust;
      done      <= wbPending;

      if (loadOps) begin
        opReg   <= op;
        signA   <= negA;
        signB   <= negB;
        origA   <= rs_data;
        counter <= CW'(WIDTH);
        accHi   <= '0;
        if (op[1]) begin
          addend <= magB;
          accLo  <= magA;
        end else begin
          addend <= magA;
          accLo  <= magB;
        end
      end

      if (doIter) begin
        accHi   <= iterHi;
        accLo   <= iterLo;
        counter <= counter - CW'(1);
      end

      if (doAdjust) begin
        resHi <= adjHi;
        resLo <= adjLo;
      end

      if (wbPending) begin
        hi <= resHi;
        lo <= resLo;
      end
      // A host move in the commit cycle is the later instruction, so it wins.
      if (hostWrHi) hi <= rs_data;
      if (hostWrLo) lo <= rs_data;
    end
  end

endmodule
